// File: rtl/ysyx_24100029_bp_pkg.sv
// Shared types, sizes and the gshare hash for the branch predictor.
package ysyx_24100029_bp_pkg;

  localparam int unsigned PHT_INDEX_WIDTH = 8;
  localparam int unsigned GHR_WIDTH       = 8;
  localparam int unsigned UPD_DEPTH       = 4;
  localparam int unsigned UPD_CNT_W       = $clog2(UPD_DEPTH) + 1;

  // 2-bit counter encodings; the MSB is the predicted direction
  typedef enum logic [1:0] {
    NOT_TAKE_S = 2'b00,
    NOT_TAKE_W = 2'b01,
    TAKE_W     = 2'b11,
    TAKE_S     = 2'b10
  } pht_cnt_e;

  typedef struct packed {
    logic [PHT_INDEX_WIDTH-1:0] idx;
    logic                       taken;
  } upd_entry_t;

  // Word-aligned PC bits XORed with the zero-extended history
  function automatic logic [PHT_INDEX_WIDTH-1:0] pht_hash(
    input logic [31:0]          pc,
    input logic [GHR_WIDTH-1:0] g
  );
    logic [PHT_INDEX_WIDTH-1:0] pc_bits;
    pc_bits = pc[PHT_INDEX_WIDTH+1:2];
    return pc_bits ^ PHT_INDEX_WIDTH'(g);
  endfunction

endpackage

// File: rtl/ysyx_24100029_bp_upd_fifo.sv
// Synchronous FIFO holding pending PHT training updates.
module ysyx_24100029_bp_upd_fifo
  import ysyx_24100029_bp_pkg::*;
#(
  parameter int unsigned DEPTH = UPD_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  upd_entry_t               push_data,
  input  logic                     pop,
  output upd_entry_t               head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  upd_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Status flags and guarded handshakes
  always_comb begin
    full_c  = (count == CNT_W'(DEPTH));
    empty_c = (count == '0);
    do_push = push && !full_c;
    do_pop  = pop && !empty_c;
    head_c  = mem[rd_ptr];
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at power-of-two depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ysyx_24100029_pht_ctrl.sv
// Gshare controller: speculative GHR, read-index hash, buffered PHT training.
module ysyx_24100029_pht_ctrl
  import ysyx_24100029_bp_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_is_branch,
  input  logic [31:0]                pred_pc,
  output logic                       pred_taken,
  output logic [GHR_WIDTH-1:0]       pred_ghr,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [31:0]                upd_pc,
  input  logic [GHR_WIDTH-1:0]       upd_ghr,
  input  logic                       upd_taken,
  input  logic                       upd_mispredict,
  output logic [PHT_INDEX_WIDTH-1:0] pht_index_r,
  input  logic                       pht_state,
  output logic [PHT_INDEX_WIDTH-1:0] pht_index_w,
  output logic                       pht_is_taken,
  output logic                       pht_w_en,
  output logic                       upd_busy
);

  logic [GHR_WIDTH-1:0] ghr_spec;
  logic                 upd_fire;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [UPD_CNT_W-1:0] fifo_count;
  upd_entry_t           push_entry;
  upd_entry_t           head_entry;

  // Lookup, accept handshake and drain muxing
  always_comb begin
    pht_index_r      = pht_hash(pred_pc, ghr_spec);
    pred_taken       = pht_state;
    pred_ghr         = ghr_spec;
    upd_ready        = !fifo_full;
    upd_fire         = upd_valid && upd_ready;
    push_entry.idx   = pht_hash(upd_pc, upd_ghr);
    push_entry.taken = upd_taken;
    upd_busy         = (fifo_count != '0);
    pht_w_en         = !fifo_empty;
    pht_index_w      = '0;
    pht_is_taken     = 1'b0;
    if (!fifo_empty) begin
      pht_index_w  = head_entry.idx;
      pht_is_taken = head_entry.taken;
    end
  end

  // Speculative history; a mispredict restore overrides a same-cycle shift
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr_spec <= '0;
    end else if (upd_fire && upd_mispredict) begin
      ghr_spec <= {upd_ghr[GHR_WIDTH-2:0], upd_taken};
    end else if (pred_valid && pred_is_branch) begin
      ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], pred_taken};
    end
  end

  ysyx_24100029_bp_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (upd_fire),
    .push_data (push_entry),
    .pop       (!fifo_empty),
    .head_c    (head_entry),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count     (fifo_count)
  );

endmodule
